// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline boundary: writeback select, stall/flush, retire counter, halt/fault shutdown.
// Optional MEM-to-EX bypass outputs are enabled by defining WB_FWD_EN.
module mem_wb_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m_valid,
  input  logic [15:0]      m_mem_out,
  input  logic [15:0]      m_alu_out,
  input  logic [15:0]      m_pc_inc,
  input  logic [1:0]       m_wb_sel,
  input  logic [2:0]       m_wr_reg,
  input  logic             m_reg_write,
  input  logic             m_halt,
  input  logic             m_err,
  input  logic             stall,
  input  logic             flush,
  output logic             w_valid,
  output logic [15:0]      w_data,
  output logic [2:0]       w_wr_reg,
  output logic             w_reg_write,
  output logic [CNT_W-1:0] retired,
  output logic             dump,
  output logic             halted,
  output logic             err,
  output logic             fwd_valid,
  output logic [2:0]       fwd_reg,
  output logic [15:0]      fwd_data
);

  function automatic logic [15:0] selectWb(input logic [1:0] sel, input logic [15:0] alu,
                                           input logic [15:0] mem, input logic [15:0] link);
    case (sel)
      2'b00:   selectWb = alu;
      2'b01:   selectWb = mem;
      2'b10:   selectWb = link;
      default: selectWb = 16'h0000;
    endcase
  endfunction

  logic wStop;
  logic mFault;
  logic haltPending;

  assign mFault      = m_valid & (m_err | (m_wb_sel == 2'b11));
  // WB holds a HALT or faulting instruction: next edge shuts the stage down
  assign haltPending = w_valid & wStop & !halted;

  // MEM -> WB boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid     <= 1'b0;
      w_data      <= 16'h0000;
      w_wr_reg    <= 3'd0;
      w_reg_write <= 1'b0;
      wStop       <= 1'b0;
      retired     <= '0;
      dump        <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      dump <= 1'b0;
      if (!halted) begin
        if (haltPending) begin
          halted      <= 1'b1;
          dump        <= 1'b1;
          w_valid     <= 1'b0;
          w_reg_write <= 1'b0;
          wStop       <= 1'b0;
        end else if (!stall) begin
          if (flush) begin
            w_valid     <= 1'b0;
            w_reg_write <= 1'b0;
            wStop       <= 1'b0;
          end else begin
            w_valid     <= m_valid;
            w_data      <= selectWb(m_wb_sel, m_alu_out, m_mem_out, m_pc_inc);
            w_wr_reg    <= m_wr_reg;
            w_reg_write <= m_valid & m_reg_write & !mFault;
            wStop       <= m_valid & (m_halt | mFault);
            if (mFault)
              err <= 1'b1;
            if (m_valid && !mFault)
              retired <= retired + 1'b1;
          end
        end
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid = w_reg_write;
  assign fwd_reg   = w_wr_reg;
  assign fwd_data  = w_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_reg   = 3'd0;
  assign fwd_data  = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized run against a behavioural model.
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_valid, m_reg_write, m_halt, m_err, stall, flush;
  logic [15:0] m_mem_out, m_alu_out, m_pc_inc;
  logic [1:0]  m_wb_sel;
  logic [2:0]  m_wr_reg;
  logic        w_valid, w_reg_write, dump, halted, err, fwd_valid;
  logic [15:0] w_data, fwd_data;
  logic [2:0]  w_wr_reg, fwd_reg;
  logic [15:0] retired;

  int tests = 0;
  int fails = 0;

  // behavioural model state
  logic        mdValid, mdRegWrite, mdStop, mdHalted, mdErr, mdDump;
  logic [15:0] mdData, mdRetired;
  logic [2:0]  mdReg;

  mem_wb_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_mem_out(m_mem_out),
    .m_alu_out(m_alu_out), .m_pc_inc(m_pc_inc), .m_wb_sel(m_wb_sel),
    .m_wr_reg(m_wr_reg), .m_reg_write(m_reg_write), .m_halt(m_halt),
    .m_err(m_err), .stall(stall), .flush(flush), .w_valid(w_valid),
    .w_data(w_data), .w_wr_reg(w_wr_reg), .w_reg_write(w_reg_write),
    .retired(retired), .dump(dump), .halted(halted), .err(err),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mdValid = 0; mdRegWrite = 0; mdStop = 0; mdHalted = 0; mdErr = 0;
    mdDump = 0; mdData = 0; mdRetired = 0; mdReg = 0;
  endtask

  // One rising edge as the specification describes it, from the inputs present at the edge
  task automatic modelEdge();
    logic fault;
    mdDump = 0;
    if (mdHalted) return;
    if (mdValid && mdStop) begin
      mdHalted = 1; mdDump = 1; mdValid = 0; mdRegWrite = 0; mdStop = 0;
      return;
    end
    if (stall) return;
    if (flush) begin
      mdValid = 0; mdRegWrite = 0; mdStop = 0;
      return;
    end
    fault      = m_valid && (m_err || m_wb_sel == 2'd3);
    mdValid    = m_valid;
    mdData     = (m_wb_sel == 2'd0) ? m_alu_out : (m_wb_sel == 2'd1) ? m_mem_out :
                 (m_wb_sel == 2'd2) ? m_pc_inc : 16'h0000;
    mdReg      = m_wr_reg;
    mdRegWrite = m_valid && m_reg_write && !fault;
    mdStop     = m_valid && (m_halt || fault);
    if (fault) mdErr = 1;
    if (m_valid && !fault) mdRetired = mdRetired + 16'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) modelEdge();
    #1;
  endtask

  task automatic idleInputs();
    m_valid = 0; m_mem_out = 0; m_alu_out = 0; m_pc_inc = 0; m_wb_sel = 0;
    m_wr_reg = 0; m_reg_write = 0; m_halt = 0; m_err = 0; stall = 0; flush = 0;
  endtask

  task automatic doReset();
    rst_n = 0;
    #1;
    modelReset();
    #2;
    rst_n = 1;
  endtask

  task automatic setInstr(input logic [1:0] sel, input logic [15:0] val, input logic [2:0] rd,
                          input logic rw, input logic hlt, input logic er);
    m_valid = 1; m_wb_sel = sel; m_wr_reg = rd; m_reg_write = rw; m_halt = hlt; m_err = er;
    m_alu_out = 16'h0a0a; m_mem_out = 16'h0b0b; m_pc_inc = 16'h0c0c;
    case (sel)
      2'd0: m_alu_out = val;
      2'd1: m_mem_out = val;
      2'd2: m_pc_inc  = val;
      default: ;
    endcase
  endtask

  task automatic test_reset();
    idleInputs();
    rst_n = 0;
    #1;
    modelReset();
    tests++;
    if ({w_valid, w_data, w_wr_reg, w_reg_write, retired, dump, halted, err} !== 40'd0) begin
      fails++;
      $display("FAIL reset_state: got valid=%b data=%h reg=%0d rw=%b ret=%0d dump=%b halted=%b err=%b, want all zero",
               w_valid, w_data, w_wr_reg, w_reg_write, retired, dump, halted, err);
    end
    tests++;
    if ({fwd_valid, fwd_reg, fwd_data} !== 20'd0) begin
      fails++; $display("FAIL reset_fwd: got %b/%0d/%h want 0", fwd_valid, fwd_reg, fwd_data);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic();
    setInstr(2'd1, 16'hBEEF, 3'd3, 1, 0, 0);
    tick();
    tests++;
    if (w_data !== 16'hBEEF || w_wr_reg !== 3'd3 || w_reg_write !== 1'b1 || w_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic_load: got data=%h reg=%0d rw=%b v=%b want BEEF/3/1/1", w_data, w_wr_reg, w_reg_write, w_valid);
    end
    tests++;
    if (retired !== 16'd1) begin
      fails++; $display("FAIL basic_retired: got %0d want 1", retired);
    end
  endtask

  task automatic test_stall();
    setInstr(2'd0, 16'h1111, 3'd4, 1, 0, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (w_data !== 16'hBEEF || w_wr_reg !== 3'd3 || w_valid !== 1'b1 || retired !== 16'd1) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got data=%h reg=%0d v=%b ret=%0d want BEEF/3/1/1", i, w_data, w_wr_reg, w_valid, retired);
      end
    end
    stall = 0;
    tick();
    tests++;
    if (w_data !== 16'h1111 || w_wr_reg !== 3'd4 || retired !== 16'd2) begin
      fails++;
      $display("FAIL stall_release: got data=%h reg=%0d ret=%0d want 1111/4/2", w_data, w_wr_reg, retired);
    end
  endtask

  task automatic test_flush();
    setInstr(2'd2, 16'h2222, 3'd6, 1, 0, 0);
    stall = 1; flush = 1;
    tick();
    tests++;
    if (w_valid !== 1'b1 || w_data !== 16'h1111 || w_reg_write !== 1'b1 || retired !== 16'd2) begin
      fails++;
      $display("FAIL stall_flush_hold: got v=%b data=%h rw=%b ret=%0d want 1/1111/1/2", w_valid, w_data, w_reg_write, retired);
    end
    stall = 0;
    tick();
    tests++;
    if (w_valid !== 1'b0 || w_reg_write !== 1'b0 || retired !== 16'd2) begin
      fails++;
      $display("FAIL flush_bubble: got v=%b rw=%b ret=%0d want 0/0/2", w_valid, w_reg_write, retired);
    end
    flush = 0;
    idleInputs();
  endtask

  task automatic test_halt();
    idleInputs();
    doReset();
    setInstr(2'd0, 16'h0042, 3'd1, 0, 1, 0);
    tick();
    tests++;
    if (w_valid !== 1'b1 || dump !== 1'b0 || halted !== 1'b0 || retired !== 16'd1) begin
      fails++;
      $display("FAIL halt_capture: got v=%b dump=%b halted=%b ret=%0d want 1/0/0/1", w_valid, dump, halted, retired);
    end
    setInstr(2'd0, 16'h5555, 3'd2, 1, 0, 0);
    tick();
    tests++;
    if (dump !== 1'b1 || halted !== 1'b1 || w_valid !== 1'b0 || w_reg_write !== 1'b0) begin
      fails++;
      $display("FAIL halt_dump: got dump=%b halted=%b v=%b rw=%b want 1/1/0/0", dump, halted, w_valid, w_reg_write);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (dump !== 1'b0 || halted !== 1'b1 || w_valid !== 1'b0 || retired !== 16'd1 || err !== 1'b0) begin
        fails++;
        $display("FAIL halt_after[%0d]: got dump=%b halted=%b v=%b ret=%0d err=%b want 0/1/0/1/0", i, dump, halted, w_valid, retired, err);
      end
    end
  endtask

  task automatic test_fault(input logic useSel);
    idleInputs();
    doReset();
    if (useSel) setInstr(2'd3, 16'h0, 3'd2, 1, 0, 0);
    else        setInstr(2'd1, 16'h7777, 3'd2, 1, 0, 1);
    tick();
    tests++;
    if (w_reg_write !== 1'b0 || retired !== 16'd0 || (useSel && w_data !== 16'h0000)) begin
      fails++;
      $display("FAIL fault_capture(sel=%b): got rw=%b ret=%0d data=%h want 0/0", useSel, w_reg_write, retired, w_data);
    end
    idleInputs();
    tick();
    tests++;
    if (dump !== 1'b1 || halted !== 1'b1 || err !== 1'b1 || retired !== 16'd0) begin
      fails++;
      $display("FAIL fault_shutdown(sel=%b): got dump=%b halted=%b err=%b ret=%0d want 1/1/1/0", useSel, dump, halted, err, retired);
    end
    tick();
    tests++;
    if (dump !== 1'b0 || halted !== 1'b1 || err !== 1'b1) begin
      fails++;
      $display("FAIL fault_after(sel=%b): got dump=%b halted=%b err=%b want 0/1/1", useSel, dump, halted, err);
    end
  endtask

  task automatic test_reset_mid();
    idleInputs();
    doReset();
    setInstr(2'd0, 16'h0001, 3'd1, 0, 1, 0);
    tick();
    idleInputs();
    #2;
    rst_n = 0;
    #1;
    modelReset();
    tests++;
    if (w_valid !== 1'b0 || halted !== 1'b0 || dump !== 1'b0 || retired !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid: got v=%b halted=%b dump=%b ret=%0d want 0/0/0/0", w_valid, halted, dump, retired);
    end
    #1;
    rst_n = 1;
    tick();
    tests++;
    if (dump !== 1'b0 || halted !== 1'b0) begin
      fails++; $display("FAIL reset_mid_cancel: got dump=%b halted=%b want 0/0", dump, halted);
    end
  endtask

  task automatic test_fwd();
    logic        expV;
    logic [2:0]  expR;
    logic [15:0] expD;
    idleInputs();
    doReset();
    setInstr(2'd0, 16'h1234, 3'd5, 1, 0, 0);
    tick();
`ifdef WB_FWD_EN
    expV = 1'b1; expR = 3'd5; expD = 16'h1234;
`else
    expV = 1'b0; expR = 3'd0; expD = 16'h0000;
`endif
    tests++;
    if (fwd_valid !== expV || fwd_reg !== expR || fwd_data !== expD) begin
      fails++;
      $display("FAIL fwd_path: got %b/%0d/%h want %b/%0d/%h", fwd_valid, fwd_reg, fwd_data, expV, expR, expD);
    end
  endtask

  task automatic test_random();
    int haltedCycles = 0;
    logic        expFv;
    logic [2:0]  expFr;
    logic [15:0] expFd;
    idleInputs();
    doReset();
    for (int c = 0; c < 600; c++) begin
      m_valid     = ($urandom_range(0, 9) < 8);
      m_mem_out   = 16'($urandom);
      m_alu_out   = 16'($urandom);
      m_pc_inc    = 16'($urandom);
      m_wb_sel    = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      m_wr_reg    = 3'($urandom);
      m_reg_write = 1'($urandom);
      m_halt      = ($urandom_range(0, 24) == 0);
      m_err       = ($urandom_range(0, 24) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      tick();
      tests++;
      if (w_valid !== mdValid || w_reg_write !== mdRegWrite || retired !== mdRetired ||
          dump !== mdDump || halted !== mdHalted || err !== mdErr) begin
        fails++;
        $display("FAIL rand_ctrl[%0d]: got v=%b rw=%b ret=%0d dump=%b h=%b err=%b want %b/%b/%0d/%b/%b/%b",
                 c, w_valid, w_reg_write, retired, dump, halted, err,
                 mdValid, mdRegWrite, mdRetired, mdDump, mdHalted, mdErr);
      end
      if (mdValid) begin
        tests++;
        if (w_data !== mdData || w_wr_reg !== mdReg) begin
          fails++;
          $display("FAIL rand_data[%0d]: got %h/r%0d want %h/r%0d", c, w_data, w_wr_reg, mdData, mdReg);
        end
      end
`ifdef WB_FWD_EN
      expFv = mdRegWrite; expFr = mdRegWrite ? mdReg : fwd_reg; expFd = mdRegWrite ? mdData : fwd_data;
`else
      expFv = 1'b0; expFr = 3'd0; expFd = 16'h0000;
`endif
      tests++;
      if (fwd_valid !== expFv || fwd_reg !== expFr || fwd_data !== expFd) begin
        fails++;
        $display("FAIL rand_fwd[%0d]: got %b/%0d/%h want %b/%0d/%h", c, fwd_valid, fwd_reg, fwd_data, expFv, expFr, expFd);
      end
      if (mdHalted) haltedCycles++;
      if (haltedCycles > 3) begin
        haltedCycles = 0;
        doReset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_halt();
    test_fault(1'b0);
    test_fault(1'b1);
    test_reset_mid();
    test_fwd();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
